// File: rtl/tape_pkg.sv
// Shared types and widths for the tape RAM arbiter.
// Grant encoding plus default address/data widths.
package tape_pkg;

  localparam int ADDR_W   = 14;
  localparam int DATA_W   = 8;
  localparam int MAX_WAIT = 4;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_VGA,
    GNT_CPU_RD,
    GNT_CPU_WR
  } grant_t;

  function automatic logic is_cpu(grant_t g);
    return (g == GNT_CPU_RD) ||
           (g == GNT_CPU_WR);
  endfunction

endpackage

// File: rtl/tape_port_arbiter.sv
// Single-port tape RAM arbiter: cpu_core (rd/wr) vs VGA scanout (rd).
// A tagged one-cell cache serves repeated scanout reads; CPU wait is bounded.
//
// Ports:
//   clk, resetn              pixel clock, async active-low reset
//   cpu_req/we/addr/wdata    CPU request, held until cpu_ack
//   cpu_ack, cpu_rdata       one-cycle completion, read data
//   vga_addr, vga_cell       scanout address, cached cell (registered)
//   ram_addr/we/wdata        RAM command (combinational from grant)
//   ram_rdata                RAM data, one cycle after address
module tape_port_arbiter #(
  parameter int ADDR_W   = tape_pkg::ADDR_W,
  parameter int DATA_W   = tape_pkg::DATA_W,
  parameter int MAX_WAIT = tape_pkg::MAX_WAIT
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_cell,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  import tape_pkg::*;

  localparam int SW = $clog2(MAX_WAIT + 1);
  localparam logic [SW-1:0] W_MAX = SW'(MAX_WAIT);

  grant_t            r_iss;
  logic [ADDR_W-1:0] r_iss_addr;
  logic [ADDR_W-1:0] r_tag;
  logic              r_tag_valid;
  logic [DATA_W-1:0] r_cell;
  logic [DATA_W-1:0] r_rdata;
  logic              r_ack;
  logic [SW-1:0]     r_starve;

  grant_t            w_gnt;
  grant_t            w_cpu_gnt;
  logic              w_fetch;
  logic              w_tag_v;
  logic [ADDR_W-1:0] w_tag;
  logic              w_miss;
  logic              w_elig;
  logic              w_force;
  logic              w_wr_hit;

  // A VGA fetch in flight counts as the tag already, so a held
  // address is not fetched twice and a write to it is not lost.
  assign w_fetch   = (r_iss == GNT_VGA);
  assign w_tag_v   = r_tag_valid | w_fetch;
  assign w_tag     = w_fetch ? r_iss_addr : r_tag;
  assign w_miss    = !w_tag_v || (vga_addr != w_tag);
  assign w_elig    = cpu_req & ~r_ack;
  assign w_force   = w_elig && (r_starve == W_MAX);
  assign w_cpu_gnt = cpu_we ? GNT_CPU_WR : GNT_CPU_RD;
  assign w_wr_hit  = (w_gnt == GNT_CPU_WR) && w_tag_v &&
                     (cpu_addr == w_tag);

  always_comb begin
    w_gnt = GNT_NONE;
    if (w_force)     w_gnt = w_cpu_gnt;
    else if (w_miss) w_gnt = GNT_VGA;
    else if (w_elig) w_gnt = w_cpu_gnt;
  end

  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (resetn) begin
      ram_wdata = cpu_wdata;
      case (w_gnt)
        GNT_CPU_RD: ram_addr = cpu_addr;
        GNT_CPU_WR: begin
          ram_addr = cpu_addr;
          ram_we   = 1'b1;
        end
        default:    ram_addr = vga_addr;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_iss       <= GNT_NONE;
      r_iss_addr  <= '0;
      r_tag       <= '0;
      r_tag_valid <= 1'b0;
      r_cell      <= '0;
      r_rdata     <= '0;
      r_ack       <= 1'b0;
      r_starve    <= '0;
    end else begin
      r_iss      <= w_gnt;
      r_iss_addr <= ram_addr;
      r_ack      <= is_cpu(w_gnt);
      if (r_iss == GNT_CPU_RD)
        r_rdata <= ram_rdata;
      if (w_fetch) begin
        r_tag       <= r_iss_addr;
        r_tag_valid <= 1'b1;
      end
      if (w_wr_hit)
        r_cell <= cpu_wdata;
      else if (w_fetch)
        r_cell <= ram_rdata;
      if (!cpu_req || is_cpu(w_gnt))
        r_starve <= '0;
      else if (w_elig && (w_gnt == GNT_VGA) &&
               (r_starve != W_MAX))
        r_starve <= r_starve + SW'(1);
    end
  end

  assign cpu_ack   = r_ack;
  assign cpu_rdata = (r_iss == GNT_CPU_RD) ? ram_rdata : r_rdata;
  assign vga_cell  = r_cell;

endmodule

// File: tb/tb_tape_port_arbiter.sv
// Self-checking bench for tape_port_arbiter.
// Directed corners, a vector table and a randomized phase.
module tb_tape_port_arbiter;

  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cpu_req;
  logic        cpu_we;
  logic [13:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic [13:0] vga_addr;
  logic [7:0]  vga_cell;
  logic [13:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  int tests = 0;
  int fails = 0;
  bit spin  = 1'b0;

  always #5 clk = ~clk;

  tape_port_arbiter dut (
    .clk       (clk),
    .resetn    (resetn),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .vga_addr  (vga_addr),
    .vga_cell  (vga_cell),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  function automatic logic [7:0] pat(logic [13:0] a);
    case (a)
      14'h0005: return 8'hA3;
      14'h0200: return 8'h5C;
      default:  return a[7:0] ^ {1'b0, a[13:7]} ^ 8'h3C;
    endcase
  endfunction

  // RAM model: one-cycle registered read, read-first on write.
  logic [7:0] mem [0:16383];
  bit         wr  [0:16383];

  function automatic logic [7:0] ram_val(logic [13:0] a);
    return wr[a] ? mem[a] : pat(a);
  endfunction

  always @(posedge clk) begin
    ram_rdata <= ram_val(ram_addr);
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
      wr[ram_addr]  <= 1'b1;
    end
  end

  // Expected RAM contents from the CPU's point of view.
  logic [7:0] shadow [0:16383];

  always @(posedge clk) begin
    #1;
    if (spin) vga_addr = vga_addr + 14'd1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string nm, logic [31:0] act,
                       logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cpu_op(input logic we, input logic [13:0] a,
                        input logic [7:0] d, output int lat,
                        output logic [7:0] rd);
    lat       = -1;
    rd        = '0;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = d;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (cpu_ack === 1'b1) begin
        lat = i;
        rd  = cpu_rdata;
        break;
      end
      step();
    end
    if (lat >= 0 && we) shadow[a] = d;
    step();
    cpu_req = 1'b0;
  endtask

  task automatic hold_vga(input logic [13:0] a, input int n);
    vga_addr = a;
    repeat (n) step();
  endtask

  typedef struct {
    logic        we;
    logic [13:0] addr;
    logic [7:0]  wdata;
    logic [13:0] vga;
    logic [7:0]  exp_rd;
    logic [7:0]  exp_cell;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int         lat;
    logic [7:0] rd;

    tbl[0] = '{1'b1, 14'h0300, 8'h11, 14'h0300, 8'h00, 8'h11};
    tbl[1] = '{1'b1, 14'h0301, 8'h22, 14'h0300, 8'h00, 8'h11};
    tbl[2] = '{1'b0, 14'h0301, 8'h00, 14'h0301, 8'h22, 8'h22};
    tbl[3] = '{1'b1, 14'h0301, 8'h33, 14'h0301, 8'h00, 8'h33};
    tbl[4] = '{1'b0, 14'h0300, 8'h00, 14'h0301, 8'h11, 8'h33};
    tbl[5] = '{1'b1, 14'h3FFF, 8'hAB, 14'h3FFF, 8'h00, 8'hAB};
    tbl[6] = '{1'b0, 14'h3FFF, 8'h00, 14'h0300, 8'hAB, 8'h11};
    tbl[7] = '{1'b1, 14'h0000, 8'h5A, 14'h0000, 8'h00, 8'h5A};
    tbl[8] = '{1'b0, 14'h0000, 8'h00, 14'h3FFF, 8'h5A, 8'hAB};

    for (int i = 0; i < 16384; i++) shadow[i] = pat(14'(i));

    // Reset state, with a CPU write held to show gating.
    resetn    = 1'b0;
    vga_addr  = 14'h0005;
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 14'h1234;
    cpu_wdata = 8'hEE;
    repeat (3) step();
    @(negedge clk);
    check("rst ram_we", ram_we, 0);
    check("rst ram_addr", ram_addr, 0);
    check("rst ram_wdata", ram_wdata, 0);
    check("rst cpu_ack", cpu_ack, 0);
    check("rst cpu_rdata", cpu_rdata, 0);
    check("rst vga_cell", vga_cell, 0);
    step();
    cpu_req = 1'b0;
    resetn  = 1'b1;

    // 1: first fetch lands two cycles later.
    @(negedge clk);
    check("t1 c0 ram_addr", ram_addr, 14'h0005);
    check("t1 c0 cell", vga_cell, 0);
    step();
    @(negedge clk);
    check("t1 c1 cell", vga_cell, 0);
    step();
    @(negedge clk);
    check("t1 c2 cell", vga_cell, 8'hA3);
    check("t1 c2 ram_we", ram_we, 0);
    step();

    // 2: CPU read while scanout address is cached.
    hold_vga(14'h0105, 4);
    @(negedge clk);
    check("t2 cell", vga_cell, pat(14'h0105));
    step();
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 14'h0200;
    @(negedge clk);
    check("t2 c0 ram_addr", ram_addr, 14'h0200);
    check("t2 c0 ack", cpu_ack, 0);
    step();
    @(negedge clk);
    check("t2 c1 ack", cpu_ack, 1);
    check("t2 c1 rdata", cpu_rdata, 8'h5C);
    step();
    cpu_req = 1'b0;
    @(negedge clk);
    check("t2 c2 ack", cpu_ack, 0);
    check("t2 c2 rdata hold", cpu_rdata, 8'h5C);
    step();

    // 4: write-through to the cached cell.
    hold_vga(14'h0042, 4);
    @(negedge clk);
    check("t4 cell", vga_cell, pat(14'h0042));
    step();
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 14'h0042;
    cpu_wdata = 8'h99;
    @(negedge clk);
    check("t4 c0 ram_we", ram_we, 1);
    check("t4 c0 cell", vga_cell, pat(14'h0042));
    step();
    @(negedge clk);
    check("t4 c1 cell", vga_cell, 8'h99);
    check("t4 c1 ack", cpu_ack, 1);
    shadow[14'h0042] = 8'h99;
    step();
    cpu_req = 1'b0;
    @(negedge clk);
    check("t4 c2 cell", vga_cell, 8'h99);
    step();

    // 5: miss and request together: VGA first, CPU next.
    vga_addr = 14'h0043;
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 14'h0042;
    @(negedge clk);
    check("t5 c0 ram_addr", ram_addr, 14'h0043);
    step();
    @(negedge clk);
    check("t5 c1 ram_addr", ram_addr, 14'h0042);
    check("t5 c1 ack", cpu_ack, 0);
    step();
    @(negedge clk);
    check("t5 c2 ack", cpu_ack, 1);
    check("t5 c2 rdata", cpu_rdata, 8'h99);
    check("t5 c2 cell", vga_cell, pat(14'h0043));
    step();
    cpu_req = 1'b0;
    step();

    // 3: constant misses; bounded wait forces a slot.
    vga_addr = 14'h1000;
    spin     = 1'b1;
    cpu_op(1'b1, 14'h0010, 8'h77, lat, rd);
    check("t3 lat", 32'(lat), MAXW + 1);
    vga_addr = 14'h1800;
    cpu_op(1'b1, 14'h0011, 8'h78, lat, rd);
    check("t3b lat", 32'(lat), MAXW + 1);
    spin = 1'b0;
    step();
    @(negedge clk);
    check("t3 ram[10]", ram_val(14'h0010), 8'h77);
    check("t3b ram[11]", ram_val(14'h0011), 8'h78);
    step();
    cpu_op(1'b0, 14'h0010, 8'h00, lat, rd);
    check("t3 readback", rd, 8'h77);

    // Vector table: cached scanout, single-slot CPU ops.
    foreach (tbl[i]) begin
      hold_vga(tbl[i].vga, 4);
      cpu_op(tbl[i].we, tbl[i].addr, tbl[i].wdata, lat, rd);
      check($sformatf("tbl%0d lat", i), 32'(lat), 1);
      if (!tbl[i].we)
        check($sformatf("tbl%0d rdata", i), rd, tbl[i].exp_rd);
      repeat (3) step();
      @(negedge clk);
      check($sformatf("tbl%0d cell", i), vga_cell,
            tbl[i].exp_cell);
      step();
    end

    // 6a: reset during a CPU write grant.
    hold_vga(14'h2100, 4);
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 14'h2200;
    cpu_wdata = 8'h44;
    #3;
    check("t6a pre ram_we", ram_we, 1);
    resetn = 1'b0;
    #1;
    check("t6a ram_we", ram_we, 0);
    check("t6a ram_addr", ram_addr, 0);
    step();
    cpu_req = 1'b0;
    @(negedge clk);
    check("t6a ack", cpu_ack, 0);
    step();
    resetn = 1'b1;
    repeat (4) step();

    // 6b: reset during a CPU read grant.
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 14'h0300;
    #3;
    check("t6b pre ram_addr", ram_addr, 14'h0300);
    resetn = 1'b0;
    #1;
    check("t6b ram_we", ram_we, 0);
    check("t6b cell", vga_cell, 0);
    check("t6b ack", cpu_ack, 0);
    step();
    cpu_req = 1'b0;
    @(negedge clk);
    check("t6b ack rst", cpu_ack, 0);
    step();
    resetn = 1'b1;
    @(negedge clk);
    check("t6b c0 ack", cpu_ack, 0);
    check("t6b c0 cell", vga_cell, 0);
    step();
    @(negedge clk);
    check("t6b c1 cell", vga_cell, 0);
    step();
    @(negedge clk);
    check("t6b c2 cell", vga_cell, pat(14'h2100));
    step();

    // Randomized traffic against the shadow memory.
    begin
      int stable = 0;
      bit busy   = 1'b0;
      bit drop   = 1'b0;
      int st     = 0;
      logic [13:0] nv;
      for (int cyc = 0; cyc < 2000; cyc++) begin
        if (drop) begin
          cpu_req = 1'b0;
          busy    = 1'b0;
          drop    = 1'b0;
        end
        nv = vga_addr;
        if ($urandom_range(0, 3) == 0)
          nv = 14'h0080 + 14'($urandom_range(0, 7));
        if (nv != vga_addr) stable = 0;
        else                stable++;
        vga_addr = nv;
        if (!busy && $urandom_range(0, 2) == 0) begin
          busy      = 1'b1;
          cpu_req   = 1'b1;
          cpu_we    = 1'($urandom_range(0, 1));
          cpu_addr  = 14'h0080 + 14'($urandom_range(0, 11));
          cpu_wdata = 8'($urandom);
          st        = cyc;
        end
        @(negedge clk);
        if (busy && !drop) begin
          if (cpu_ack === 1'b1) begin
            check("rnd lat ok", 32'(cyc - st <= MAXW + 1), 1);
            if (!cpu_we)
              check("rnd rdata", cpu_rdata, shadow[cpu_addr]);
            else
              shadow[cpu_addr] = cpu_wdata;
            drop = 1'b1;
          end else if (cyc - st > MAXW + 1) begin
            tests++;
            fails++;
            $display("FAIL rnd ack timeout: addr %0h", cpu_addr);
            drop = 1'b1;
          end
        end
        if (stable >= 3)
          check("rnd cell", vga_cell, shadow[vga_addr]);
        step();
      end
      cpu_req = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
